// File: rtl/soc_system_sysid_ext.sv
// System ID / build-info register block with scratch words and optional
// 64-bit uptime counter (enabled by SOC_SYSTEM_SYSID_UPTIME_EN).
module soc_system_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID   = 32'h0000_1110,
  parameter logic [31:0] TIMESTAMP   = 32'd1546432878,
  parameter logic [31:0] VERSION     = 32'h0001_0000,
  parameter int          NUM_SCRATCH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic [31:0] scratch [NUM_SCRATCH];
  logic [31:0] up_lo;
  logic [31:0] up_hi;
  logic [31:0] ctrl_rd;
  logic [31:0] rd_mux;

`ifdef SOC_SYSTEM_SYSID_UPTIME_EN
  localparam logic UP_BIT = 1'b1;

  logic [63:0] cnt;
  logic [31:0] hi_sh;
  logic        freeze;
  logic        ctrl_wr;
  logic        clr;

  assign ctrl_wr = write && (address == 4'd6);
  assign clr     = ctrl_wr && writedata[0];

  // Clear wins over increment; FREEZE only gates increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= cnt + 64'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freeze <= 1'b0;
    end else if (ctrl_wr && byteenable[0]) begin
      freeze <= writedata[1];
    end
  end

  // Reading LO snapshots HI so a LO/HI pair is coherent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_sh <= '0;
    end else if (read && (address == 4'd4)) begin
      hi_sh <= cnt[63:32];
    end
  end

  assign up_lo   = cnt[31:0];
  assign up_hi   = hi_sh;
  assign ctrl_rd = {30'd0, freeze, 1'b0};
`else
  localparam logic UP_BIT = 1'b0;

  assign up_lo   = '0;
  assign up_hi   = '0;
  assign ctrl_rd = '0;
`endif

  localparam logic [31:0] CAPS =
    {24'd0, 4'(NUM_SCRATCH), 3'd0, UP_BIT};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch[i] <= '0;
      end
    end else if (write) begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (address == 4'(8 + i)) begin
          for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) begin
              scratch[i][8*b +: 8] <= writedata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      4'd0:    rd_mux = SYSTEM_ID;
      4'd1:    rd_mux = TIMESTAMP;
      4'd2:    rd_mux = VERSION;
      4'd3:    rd_mux = CAPS;
      4'd4:    rd_mux = up_lo;
      4'd5:    rd_mux = up_hi;
      4'd6:    rd_mux = ctrl_rd;
      default: rd_mux = '0;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (address == 4'(8 + i)) begin
        rd_mux = scratch[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// Self-checking bench for soc_system_sysid_ext: reference model compared
// every cycle plus directed literal checks.
module tb_soc_system_sysid_ext;

  localparam int NS = 4;
`ifdef SOC_SYSTEM_SYSID_UPTIME_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int n_pass = 0;
  int n_tot  = 0;

  soc_system_sysid_ext dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Reference model: register map as plain arrays and a 64-bit integer.
  logic [31:0] m_scr [8];
  logic [63:0] m_cnt;
  logic [31:0] m_sh;
  logic        m_frz;
  logic [31:0] m_data;
  logic        m_valid;

  function automatic logic [31:0] m_read(logic [3:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return 32'h0000_1110;
    if (ai == 1) return 32'd1546432878;
    if (ai == 2) return 32'h0001_0000;
    if (ai == 3) return (NS * 16) + (UP ? 1 : 0);
    if (UP && ai == 4) return m_cnt[31:0];
    if (UP && ai == 5) return m_sh;
    if (UP && ai == 6) return m_frz ? 32'd2 : 32'd0;
    if (ai >= 8 && ai < 8 + NS) return m_scr[ai-8];
    return 32'd0;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_scr[i] = '0;
      m_cnt = '0; m_sh = '0; m_frz = 1'b0;
      m_data = '0; m_valid = 1'b0;
    end else begin
      logic [63:0] nc;
      m_valid = read;
      if (read) begin
        m_data = m_read(address);
        if (UP && address == 4'd4) m_sh = m_cnt[63:32];
      end
      nc = m_cnt;
      if (UP) begin
        if (write && address == 4'd6 && writedata[0]) nc = 0;
        else if (!m_frz) nc = m_cnt + 1;
        if (write && address == 4'd6 && byteenable[0])
          m_frz = writedata[1];
      end
      m_cnt = nc;
      if (write && int'(address) >= 8 && int'(address) < 8 + NS)
        for (int b = 0; b < 4; b++)
          if (byteenable[b])
            m_scr[int'(address)-8][8*b +: 8] = writedata[8*b +: 8];
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("rdv_model", {31'd0, readdatavalid}, {31'd0, m_valid});
      chk("rdata_model", readdata, m_data);
    end
  end

  task automatic wr(logic [3:0] a, logic [31:0] d, logic [3:0] be);
    @(negedge clock);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic rd(logic [3:0] a, output logic [31:0] d);
    @(negedge clock);
    address = a; read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    chk("rd_valid", {31'd0, readdatavalid}, 32'd1);
    d = readdata;
  endtask

  logic [31:0] v;

  initial begin
    #2;
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_rdv", {31'd0, readdatavalid}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    rd(4'd0, v); chk("id", v, 32'h0000_1110);
    rd(4'd1, v); chk("timestamp", v, 32'd1546432878);
    rd(4'd2, v); chk("version", v, 32'h0001_0000);
    rd(4'd3, v); chk("caps", v, UP ? 32'h0000_0041 : 32'h0000_0040);
    @(negedge clock);
    chk("rdv_one_cycle", {31'd0, readdatavalid}, 32'd0);
    chk("rdata_hold", readdata, UP ? 32'h0000_0041 : 32'h0000_0040);

    wr(4'd8, 32'hDEADBEEF, 4'b0101);
    rd(4'd8, v); chk("scr_bytes", v, 32'h00AD00EF);
    wr(4'd15, 32'h1234_5678, 4'hF);
    rd(4'd15, v); chk("unmapped15", v, 32'd0);
    wr(4'd7, 32'h1111_1111, 4'hF);
    rd(4'd7, v); chk("unmapped7", v, 32'd0);
    wr(4'd0, 32'hFFFF_FFFF, 4'hF);
    rd(4'd0, v); chk("ro_ignore", v, 32'h0000_1110);
    wr(4'd11, 32'hCAFE_F00D, 4'hF);
    rd(4'd11, v); chk("scr_last", v, 32'hCAFE_F00D);

    // Same-edge read and write returns the old value.
    @(negedge clock);
    address = 4'd9; read = 1'b1; write = 1'b1;
    writedata = 32'hA5A5_5A5A; byteenable = 4'hF;
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    chk("rw_old", readdata, 32'd0);
    rd(4'd9, v); chk("rw_new", v, 32'hA5A5_5A5A);

`ifdef SOC_SYSTEM_SYSID_UPTIME_EN
    @(negedge clock);
    force dut.cnt = 64'h0000_0001_FFFF_FFFF;
    m_cnt = 64'h0000_0001_FFFF_FFFF;
    #1 release dut.cnt;
    address = 4'd4; read = 1'b1;
    @(negedge clock);
    read = 1'b0;
    chk("up_lo_force", readdata, 32'hFFFF_FFFF);
    @(negedge clock);
    rd(4'd5, v); chk("up_hi_shadow", v, 32'h0000_0001);

    wr(4'd6, 32'h3, 4'hF);
    repeat (10) @(negedge clock);
    rd(4'd4, v); chk("clr_frz_lo", v, 32'd0);
    rd(4'd6, v); chk("ctrl_rd", v, 32'd2);
    wr(4'd6, 32'h0, 4'hF);
    rd(4'd4, v);
    chk("lo_small", {31'd0, (v != 0 && v < 8)}, 32'd1);
`else
    rd(4'd4, v); chk("no_up_lo", v, 32'd0);
    wr(4'd6, 32'h3, 4'hF);
    rd(4'd6, v); chk("no_ctrl", v, 32'd0);
    rd(4'd5, v); chk("no_up_hi", v, 32'd0);
`endif

    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      read = 1'($urandom_range(0, 1));
      address = 4'($urandom_range(0, 15));
      write = ($urandom_range(0, 3) == 0);
      writedata = $urandom;
      byteenable = 4'($urandom_range(0, 15));
    end
    @(negedge clock);
    read = 1'b0; write = 1'b0;

    // Reset landing between the read edge and the data sample.
    wr(4'd8, 32'h1234_5678, 4'hF);
    @(negedge clock);
    address = 4'd8; read = 1'b1;
    @(posedge clock);
    #1 reset_n = 1'b0; read = 1'b0;
    @(negedge clock);
    chk("rst_mid_rdv", {31'd0, readdatavalid}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rd(4'd8, v); chk("scr_after_rst", v, 32'd0);
    rd(4'd3, v); chk("caps_after_rst", v, UP ? 32'h41 : 32'h40);

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/soc_system_sysid_ext.md
SOC_SYSTEM_SYSID_EXT -- requirements
Module: soc_system_sysid_ext

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- SYSTEM_ID, 32'h0000_1110, value returned at word 0.
- TIMESTAMP, 32'd1546432878, build timestamp returned at word 1.
- VERSION, 32'h0001_0000, register-map version returned at word 2.
- NUM_SCRATCH, 4, number of read/write scratch words; legal range 1..8.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- address, in, 4, word address.
- read, in, 1, read strobe.
- write, in, 1, write strobe.
- writedata, in, 32, write data.
- byteenable, in, 4, byte-lane write enables.
- readdata, out, 32, registered read data.
- readdatavalid, out, 1, read data qualifier.
REQ-003 The block SHALL use one clock, clock; reset_n SHALL be asynchronous and active-low.

Function
REQ-004 The word map SHALL be:
- 0 ID (RO).
- 1 TIMESTAMP (RO).
- 2 VERSION (RO).
- 3 CAPS (RO): bit0 = uptime present; bits[7:4] = NUM_SCRATCH; all other bits 0.
- 4 UPTIME_LO (RO).
- 5 UPTIME_HI (RO, shadow).
- 6 CTRL (RW): bit0 CLEAR, write-1 self-clearing, reads 0; bit1 FREEZE.
- 8..8+NUM_SCRATCH-1 SCRATCH (RW).
REQ-005 Read latency SHALL be exactly 1 cycle: a read sampled at edge N SHALL present readdata with readdatavalid=1 after edge N+1, for that cycle only.
REQ-006 readdatavalid SHALL be 0 in any cycle not following a sampled read.
REQ-007 readdata SHALL hold its last value while readdatavalid=0.
REQ-008 Unmapped addresses (7, and 8+NUM_SCRATCH..15) SHALL read 0, and writes to them SHALL be ignored.
REQ-009 Writes to RO words SHALL be ignored.
REQ-010 Scratch writes SHALL update only the byte lanes whose byteenable bit is 1.
REQ-011 Simultaneous read and write to the same word SHALL return the pre-write value; the write SHALL take effect at the same edge.
REQ-012 The 64-bit uptime counter SHALL increment by 1 each clock while FREEZE=0, and SHALL wrap from 2^64-1 to 0.
REQ-013 A read of UPTIME_LO SHALL return counter[31:0] and, at the same edge, latch counter[63:32] into the HI shadow.
REQ-014 A read of UPTIME_HI SHALL return the shadow, never the live upper word.
REQ-015 Writing CTRL with bit0=1 SHALL load the counter with 0 at that edge; CLEAR SHALL take priority over increment; the shadow SHALL be unaffected.
REQ-016 A CTRL write SHALL update FREEZE from bit1 when byteenable[0]=1.
REQ-017 A CTRL write with CLEAR=1 and FREEZE=1 SHALL leave the counter at 0 and held.

Reset
REQ-018 Asserting reset_n low SHALL clear, immediately and regardless of the clock:
- readdata and readdatavalid;
- all scratch words;
- FREEZE;
- the counter and the HI shadow.
REQ-019 Reset asserted mid-read SHALL suppress that read's readdatavalid.
REQ-020 After reset_n deasserts, the first sampled clock edge SHALL be the counter's first increment (value 1).

Configuration
REQ-021 With macro SOC_SYSTEM_SYSID_UPTIME_EN defined, the uptime counter, HI shadow and CTRL register SHALL be present, and CAPS bit0 SHALL read 1.
REQ-022 Without SOC_SYSTEM_SYSID_UPTIME_EN:
- words 4, 5 and 6 SHALL read 0 and ignore writes;
- CAPS bit0 SHALL read 0;
- no counter flops SHALL be synthesized.

Verification
REQ-023 Defaults, reads of words 0, 1, 2, 3 -> 32'h0000_1110, 32'd1546432878, 32'h0001_0000, 32'h0000_0041 respectively, each with readdatavalid exactly one cycle after read.
REQ-024 Write 32'hDEADBEEF to word 8 with byteenable=4'b0101, then read -> 32'h00AD00EF; read word 15 -> 0.
REQ-025 Force counter to 64'h0000_0001_FFFF_FFFF, read UPTIME_LO -> 32'hFFFF_FFFF; read UPTIME_HI 3 cycles later -> 32'h0000_0001, not 2.
REQ-026 Write CTRL=32'h3, wait 10 cycles, read UPTIME_LO -> 0; write CTRL=0, read UPTIME_LO 1 cycle after the write -> small nonzero value.
REQ-027 Assert reset_n low between the read edge and the data cycle -> readdatavalid stays 0, and scratch word 8 reads 0 after release.
REQ-028 Build without SOC_SYSTEM_SYSID_UPTIME_EN, read CAPS -> 32'h0000_0040; read word 4 -> 0.
